irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller between the VIA/UART IRQ pins and the 6502 IRQB.
//  Synchronises each active-low source, latches or follows it (per-source mode),
//  masks it, and drives one registered active-low irq_n. Replaces the direct via2_irq wiring.
//  CPU access through a register window in the bifrost_cs space, decoded from the address bus.
// PARAMETERS
//  NSRC     8  number of IRQ sources (1..8); bit0 via1, bit1 via2, bit2 uart, 3..6 uart tx/rx b/a
//  SYNC_LEN 2  synchroniser flops per source (>=2)
// PORTS
//  clock      in   1     system clock (8 MHz); all state on posedge
//  reset      in   1     synchronous, active-high
//  src_n      in   NSRC  raw active-low IRQ inputs (asynchronous)
//  cs_n       in   1     register window select, active low (bifrost_cs)
//  rw         in   1     6502 R/W: 1 read, 0 write
//  reg_addr   in   3     register offset (addr[2:0])
//  wdata      in   8     CPU write data
//  rdata      out  8     read data, valid while cs_n=0 && rw=1
//  rdata_oe   out  1     1 while cs_n=0 && rw=1 (top-level tristate enable)
//  irq_n      out  1     to 6502 IRQB, active low, registered
// BEHAVIOUR
//  Reset values: irq_n=1, rdata=0, rdata_oe=0, ENABLE=00, MODE=FF, PEND=0, sync flops=1, bus FSM=IDLE.
//  Registers (bits >= NSRC read 0, ignore writes):
//   0 STATUS  R    PEND
//   1 ENABLE  R/W  mask, 1=enabled
//   2 ACK     W1C  write 1 clears PEND bit of edge-mode sources; reads 00
//   3 ACTIVE  R    PEND & ENABLE
//   4 SOURCE  R    see CONFIGURATION
//   5 MODE    R/W  1=level, 0=edge
//   6,7       R 00, writes ignored
//  Sync: src_n passes SYNC_LEN flops -> s_n; assert event = s_n 1->0 vs previous sample.
//  PEND: level mode -> PEND[i] = ~s_n[i] each cycle (ACK no effect). Edge mode -> set on
//   assert event, cleared by ACK commit; set and clear same cycle -> set wins.
//  MODE change 1->0 keeps current PEND value; 0->1 overwrites with level next cycle.
//  irq_n <= ~|(PEND & ENABLE): one cycle after PEND/ENABLE change; pin-to-irq_n
//   latency = SYNC_LEN+2 cycles.
//  Bus FSM (6502 data is late in phi2, so writes commit at end of access):
//   IDLE: cs_n=0&rw=0 -> WR; cs_n=0&rw=1 -> RD.
//   WR: wdata/reg_addr captured every cycle; cs_n=1 -> commit last capture, -> IDLE.
//   RD: rdata combinational from reg_addr; cs_n=1 -> IDLE, no side effect.
//   rw flips while cs_n=0 -> follow new direction, discard pending write.
//  Exactly one commit per write access regardless of its length in clocks.
//  Commit and reset same cycle -> reset wins; reset mid-access returns FSM to IDLE, no commit.
// CONFIGURATION
//  IRQ_SOURCE_EN defined: SOURCE reg = {active_any, 4'b0, idx[2:0]}
//   idx = lowest-numbered set bit of PEND & ENABLE; 00 when none active.
//  IRQ_SOURCE_EN undefined: no encoder logic; offset 4 reads 00.
// STRUCTURE
//  irq_defs.vh (shared include): register offset localparams IRQ_REG_STATUS..IRQ_REG_MODE,
//   source bit indices IRQ_SRC_VIA1/VIA2/UART..., reset constants.
//  Sub-module irq_sync: SYNC_LEN-flop synchroniser + assert-edge detect, one per source (generate).
//  irq_ctrl keeps PEND/ENABLE/MODE, bus FSM, read mux, irq_n flop.
// TESTING
//  1 Reset, read all regs -> STATUS/ACTIVE/ENABLE=00, MODE=FF, irq_n=1.
//  2 MODE=FD, ENABLE=02, pulse src_n[1] low 3 clocks -> STATUS=02, irq_n=0 at SYNC_LEN+2;
//    ACK=02 -> irq_n=1 one cycle after cs_n rises.
//  3 Level mode, ENABLE=01, hold src_n[0] low -> irq_n=0; ACK=01 -> no change;
//    release src_n[0] -> irq_n=1 after SYNC_LEN+2.
//  4 Write ENABLE=0x5A, cs_n low 8 clocks, wdata valid only last 2 -> exactly one commit,
//    ENABLE reads 0x5A.
//  5 Edge src 2 asserts in the cycle an ACK=04 commits -> STATUS bit2 stays 1.
//  6 IRQ_SOURCE_EN: PEND=0x14, ENABLE=FF -> SOURCE=0x82; ENABLE=00 -> 00. Undefined -> 00.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, reset values,
// bus FSM states and the lowest-set-bit encoder used by the optional SOURCE register.
package irq_ctrl_pkg;

    localparam logic [2:0] IRQ_REG_STATUS = 3'd0;
    localparam logic [2:0] IRQ_REG_ENABLE = 3'd1;
    localparam logic [2:0] IRQ_REG_ACK    = 3'd2;
    localparam logic [2:0] IRQ_REG_ACTIVE = 3'd3;
    localparam logic [2:0] IRQ_REG_SOURCE = 3'd4;
    localparam logic [2:0] IRQ_REG_MODE   = 3'd5;

    localparam logic [7:0] IRQ_ENABLE_RST = 8'h00;
    localparam logic [7:0] IRQ_MODE_RST   = 8'hFF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2
    } bus_state_e;

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side register window of the interrupt controller (bifrost_cs space).
interface irq_ctrl_if;

    logic       cs_n;
    logic       rw;
    logic [2:0] reg_addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_oe;

    modport master (
        output cs_n, rw, reg_addr, wdata,
        input  rdata, rdata_oe
    );

    modport slave (
        input  cs_n, rw, reg_addr, wdata,
        output rdata, rdata_oe
    );

endinterface

// File: rtl/irq_ctrl_sync.sv
// Per-source synchroniser for an asynchronous active-low IRQ pin, plus detection of the
// high-to-low (assert) transition on the synchronised level.
module irq_ctrl_sync #(
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic src_n,
    output logic s_n,
    output logic fall
);

    logic [SYNC_LEN-1:0] chain_q;
    logic                prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            chain_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            chain_q <= {chain_q[SYNC_LEN-2:0], src_n};
            prev_q  <= chain_q[SYNC_LEN-1];
        end
    end

    assign s_n  = chain_q[SYNC_LEN-1];
    assign fall = prev_q & ~s_n;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises, latches/follows and masks up to 8 active-low sources
// into one registered irq_n. Define IRQ_SOURCE_EN to enable the SOURCE priority encoder.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NSRC     = 8,
    parameter int unsigned SYNC_LEN = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] src_n,
    irq_ctrl_if.slave       bus,
    output logic            irq_n
);

    logic [NSRC-1:0] s_n;
    logic [NSRC-1:0] fall;

    for (genvar i = 0; i < NSRC; i++) begin : g_sync
        irq_ctrl_sync #(
            .SYNC_LEN(SYNC_LEN)
        ) u_sync (
            .clock(clock),
            .reset(reset),
            .src_n(src_n[i]),
            .s_n  (s_n[i]),
            .fall (fall[i])
        );
    end

    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] enable_q;
    logic [NSRC-1:0] mode_q;
    logic            irq_n_q;

    bus_state_e state_q, state_d;
    logic [2:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       capture;
    logic       commit;

    // Write data arrives late in the access, so keep re-capturing and commit on cs_n release.
    assign capture = ~bus.cs_n & ~bus.rw;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.cs_n) state_d = bus.rw ? StRd : StWr;
            end
            StWr: begin
                if (bus.cs_n) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                end else if (bus.rw) begin
                    state_d = StRd;
                end
            end
            StRd: begin
                if (bus.cs_n) state_d = StIdle;
                else if (!bus.rw) state_d = StWr;
            end
            default: state_d = StIdle;
        endcase
    end

    logic [NSRC-1:0] wr_bits;
    logic [NSRC-1:0] ack_clr;

    assign wr_bits = wr_data_q[NSRC-1:0];
    assign ack_clr = (commit && wr_addr_q == IRQ_REG_ACK) ? wr_bits : '0;

    // Edge sources: a new assert event beats a simultaneous ACK.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NSRC; i++) begin
            if (mode_q[i]) pend_d[i] = ~s_n[i];
            else           pend_d[i] = fall[i] | (pend_q[i] & ~ack_clr[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            wr_addr_q <= 3'd0;
            wr_data_q <= 8'h00;
            pend_q    <= '0;
            enable_q  <= IRQ_ENABLE_RST[NSRC-1:0];
            mode_q    <= IRQ_MODE_RST[NSRC-1:0];
            irq_n_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (capture) begin
                wr_addr_q <= bus.reg_addr;
                wr_data_q <= bus.wdata;
            end
            if (commit && wr_addr_q == IRQ_REG_ENABLE) enable_q <= wr_bits;
            if (commit && wr_addr_q == IRQ_REG_MODE)   mode_q   <= wr_bits;
            pend_q  <= pend_d;
            irq_n_q <= ~|(pend_q & enable_q);
        end
    end

    assign irq_n = irq_n_q;

    logic [7:0] pend8;
    logic [7:0] enable8;
    logic [7:0] mode8;
    logic [7:0] active8;
    logic [7:0] source8;
    logic [7:0] rd_mux;

    assign pend8   = 8'(pend_q);
    assign enable8 = 8'(enable_q);
    assign mode8   = 8'(mode_q);
    assign active8 = pend8 & enable8;

`ifdef IRQ_SOURCE_EN
    assign source8 = {|active8, 4'b0000, lowest_set(active8)};
`else
    assign source8 = 8'h00;
`endif

    always_comb begin
        rd_mux = 8'h00;
        unique case (bus.reg_addr)
            IRQ_REG_STATUS: rd_mux = pend8;
            IRQ_REG_ENABLE: rd_mux = enable8;
            IRQ_REG_ACTIVE: rd_mux = active8;
            IRQ_REG_SOURCE: rd_mux = source8;
            IRQ_REG_MODE:   rd_mux = mode8;
            default:        rd_mux = 8'h00;
        endcase
    end

    assign bus.rdata_oe = ~bus.cs_n & bus.rw & ~reset;
    assign bus.rdata    = bus.rdata_oe ? rd_mux : 8'h00;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl: reset state, edge/level pend, ACK, long and
// aborted writes, ACK-vs-assert collision, reset mid-access and the SOURCE encoder.
module tb_irq_ctrl;

    localparam int unsigned NSRC     = 8;
    localparam int unsigned SYNC_LEN = 2;

    logic            clock;
    logic            reset;
    logic [NSRC-1:0] src_n;
    logic            irq_n;

    irq_ctrl_if bus_if ();

    irq_ctrl #(
        .NSRC    (NSRC),
        .SYNC_LEN(SYNC_LEN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .src_n(src_n),
        .bus  (bus_if.slave),
        .irq_n(irq_n)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [7:0] data);
        bus_if.cs_n     = 1'b0;
        bus_if.rw       = 1'b0;
        bus_if.reg_addr = addr;
        bus_if.wdata    = data;
        step();
        bus_if.cs_n = 1'b1;
        bus_if.rw   = 1'b1;
        step();
    endtask

    task automatic rd_check(input string tag, input logic [2:0] addr, input logic [7:0] exp);
        bus_if.cs_n     = 1'b0;
        bus_if.rw       = 1'b1;
        bus_if.reg_addr = addr;
        #1;
        check_val(tag, bus_if.rdata, exp);
        step();
        bus_if.cs_n = 1'b1;
        step();
    endtask

    logic [7:0] src_exp;

    initial begin
        reset           = 1'b1;
        src_n           = '1;
        bus_if.cs_n     = 1'b1;
        bus_if.rw       = 1'b1;
        bus_if.reg_addr = 3'd0;
        bus_if.wdata    = 8'h00;
        @(negedge clock);
        repeat (3) step();
        check_val("rst_irq_n", 8'(irq_n), 8'h01);
        check_val("rst_oe", 8'(bus_if.rdata_oe), 8'h00);
        check_val("rst_rdata", bus_if.rdata, 8'h00);
        reset = 1'b0;
        step();

        // Reset register contents
        rd_check("rst_status", 3'd0, 8'h00);
        rd_check("rst_enable", 3'd1, 8'h00);
        rd_check("rst_ack", 3'd2, 8'h00);
        rd_check("rst_active", 3'd3, 8'h00);
        rd_check("rst_source", 3'd4, 8'h00);
        rd_check("rst_mode", 3'd5, 8'hFF);
        rd_check("rst_reg6", 3'd6, 8'h00);

        // Edge-mode source 1, pulse of 3 clocks
        bus_write(3'd5, 8'hFD);
        bus_write(3'd1, 8'h02);
        rd_check("mode_fd", 3'd5, 8'hFD);
        src_n[1] = 1'b0;
        repeat (3) step();
        src_n[1] = 1'b1;
        check_val("edge_lat_early", 8'(irq_n), 8'h01);
        step();
        check_val("edge_lat", 8'(irq_n), 8'h00);
        repeat (4) step();
        rd_check("edge_status", 3'd0, 8'h02);
        rd_check("edge_active", 3'd3, 8'h02);
        bus_write(3'd2, 8'h02);
        step();
        check_val("edge_ack_irq", 8'(irq_n), 8'h01);
        rd_check("edge_ack_status", 3'd0, 8'h00);

        // Level-mode source 0: ACK has no effect
        bus_write(3'd5, 8'hFF);
        bus_write(3'd1, 8'h01);
        src_n[0] = 1'b0;
        repeat (3) step();
        check_val("lvl_lat_early", 8'(irq_n), 8'h01);
        step();
        check_val("lvl_lat", 8'(irq_n), 8'h00);
        bus_write(3'd2, 8'h01);
        check_val("lvl_ack_irq", 8'(irq_n), 8'h00);
        rd_check("lvl_ack_status", 3'd0, 8'h01);
        src_n[0] = 1'b1;
        repeat (3) step();
        check_val("lvl_rel_early", 8'(irq_n), 8'h00);
        step();
        check_val("lvl_rel", 8'(irq_n), 8'h01);

        // Long write: 8 clocks with cs_n low, data valid only in the last 2
        bus_if.cs_n     = 1'b0;
        bus_if.rw       = 1'b0;
        bus_if.reg_addr = 3'd1;
        for (int i = 0; i < 6; i++) begin
            bus_if.wdata = 8'(8'hC3 + i);
            step();
        end
        bus_if.wdata = 8'h5A;
        repeat (2) step();
        bus_if.cs_n = 1'b1;
        bus_if.rw   = 1'b1;
        step();
        rd_check("long_wr_enable", 3'd1, 8'h5A);

        // rw flips mid-access: pending write discarded, read proceeds
        bus_if.cs_n     = 1'b0;
        bus_if.rw       = 1'b0;
        bus_if.reg_addr = 3'd1;
        bus_if.wdata    = 8'hFF;
        step();
        bus_if.rw = 1'b1;
        #1;
        check_val("flip_rdata", bus_if.rdata, 8'h5A);
        step();
        bus_if.cs_n = 1'b1;
        step();
        rd_check("flip_enable", 3'd1, 8'h5A);

        // Writes to offsets 6/7 are ignored
        bus_write(3'd7, 8'hFF);
        rd_check("reg7", 3'd7, 8'h00);

        // Reset mid-access: no commit
        bus_if.cs_n     = 1'b0;
        bus_if.rw       = 1'b0;
        bus_if.reg_addr = 3'd1;
        bus_if.wdata    = 8'h11;
        step();
        reset       = 1'b1;
        bus_if.cs_n = 1'b1;
        bus_if.rw   = 1'b1;
        step();
        reset = 1'b0;
        step();
        rd_check("rst_mid_enable", 3'd1, 8'h00);

        // ACK commit in the same cycle as an assert event on edge source 2
        bus_write(3'd5, 8'hFB);
        bus_write(3'd1, 8'h04);
        src_n[2] = 1'b0;
        step();
        bus_if.cs_n     = 1'b0;
        bus_if.rw       = 1'b0;
        bus_if.reg_addr = 3'd2;
        bus_if.wdata    = 8'h04;
        step();
        bus_if.cs_n = 1'b1;
        bus_if.rw   = 1'b1;
        step();
        rd_check("collide_status", 3'd0, 8'h04);
        bus_write(3'd2, 8'h04);
        rd_check("collide_ack", 3'd0, 8'h00);
        src_n[2] = 1'b1;
        repeat (4) step();

        // SOURCE encoder with PEND = 0x14
        bus_write(3'd5, 8'hEB);
        bus_write(3'd2, 8'hFF);
        src_n = 8'hEB;
        repeat (4) step();
        src_n = '1;
        repeat (2) step();
        rd_check("src_status", 3'd0, 8'h14);
        bus_write(3'd1, 8'hFF);
        rd_check("src_active", 3'd3, 8'h14);
`ifdef IRQ_SOURCE_EN
        src_exp = 8'h82;
`else
        src_exp = 8'h00;
`endif
        rd_check("source_ff", 3'd4, src_exp);
`ifdef IRQ_SOURCE_EN
        src_exp = 8'h84;
`else
        src_exp = 8'h00;
`endif
        bus_write(3'd1, 8'h10);
        rd_check("source_10", 3'd4, src_exp);
        check_val("src_irq_on", 8'(irq_n), 8'h00);
        bus_write(3'd1, 8'h00);
        rd_check("source_00", 3'd4, 8'h00);
        rd_check("active_00", 3'd3, 8'h00);
        step();
        check_val("src_irq_off", 8'(irq_n), 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
